mc_controller: RTL and testbench

Parametrised multicycle RV32I control unit, the successor to the lab multicycle controller. It drives the shared multicycle datapath (PC, IR, OldPC, ALUOut, Data registers; single unified memory) from an explicit main FSM. Beyond the previous generation it adds:
- full RV32I control flow: all six branches, JALR, LUI, AUIPC
- a memory-ready wait-state handshake
- a sticky illegal-opcode trap

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_controller_if.sv | 38 +++
 rtl/mc_aludec.sv | 39 +++
 rtl/mc_controller.sv | 193 +++++++++++++++++++
 tb/tb_mc_controller.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM states, datapath
// select codes, ALU operation codes and the RV32I major opcodes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRPC,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> multicycle datapath bundle: instruction fields and ALU flags
// in, control word out. master = controller side, slave = datapath side.
interface mc_controller_if #(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 neg;
    logic                 carry;
    logic                 ovf;
    logic                 MemReady;
    logic [IMMSRC_W-1:0]  ImmSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic                 AdrSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 RegWrite;
    logic                 MemWrite;
    logic                 Illegal;

    modport master (
        input  op, funct3, funct7b5, zero, neg, carry, ovf, MemReady,
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, neg, carry, ovf, MemReady,
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, Illegal
    );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5/op[5] to an ALUControl code,
// zero-extended to ALUCTRL_W.
module mc_aludec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [1:0]           alu_op_i,
    input  logic [2:0]           funct3_i,
    input  logic                 funct7b5_i,
    input  logic                 op5_i,
    output logic [ALUCTRL_W-1:0] alu_control_o
);
    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // addi carries imm[10] in bit 30, so only R-type may subtract
                    3'b000:  code = (funct7b5_i && op5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control_o = ALUCTRL_W'(code);
endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: main FSM, inline immediate-source and branch
// decode. Define MC_MEMREADY_EN to stall FETCH/MEMREAD/MEMWRITE on MemReady.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3
) (
    input  logic          clk,
    input  logic          reset,
    mc_controller_if.master bus
);
    state_t     state_q;
    state_t     state_d;
    logic       mem_ready;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       branch_cond;

`ifdef MC_MEMREADY_EN
    assign mem_ready = bus.MemReady;
`else
    logic unused_memready;
    assign unused_memready = bus.MemReady;
    assign mem_ready       = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    // ALUOut latches OldPC+imm here, so AUIPC can write back next
                    OP_AUIPC:          state_d = S_ALUWB;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a   = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                src_a   = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                src_a     = SRCA_OLDPC;
                src_b     = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = S_JALRPC;
            end
            S_JALRPC: begin
                // PC takes the target from ALUOut while OldPC+4 lands in ALUOut
                src_a     = SRCA_OLDPC;
                src_b     = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                src_a   = SRCA_ZERO;
                src_b   = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imm_src = IMM_I;
        case (bus.op)
            OP_STORE:          imm_src = IMM_S;
            OP_BRANCH:         imm_src = IMM_B;
            OP_JAL:            imm_src = IMM_J;
            OP_LUI, OP_AUIPC:  imm_src = IMM_U;
            default:           imm_src = IMM_I;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (bus.funct3)
            3'b000:  branch_cond = bus.zero;
            3'b001:  branch_cond = ~bus.zero;
            3'b100:  branch_cond = bus.neg ^ bus.ovf;
            3'b101:  branch_cond = ~(bus.neg ^ bus.ovf);
            3'b110:  branch_cond = ~bus.carry;
            3'b111:  branch_cond = bus.carry;
            default: branch_cond = 1'b0;
        endcase
    end

    mc_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
        .alu_op_i      (alu_op),
        .funct3_i      (bus.funct3),
        .funct7b5_i    (bus.funct7b5),
        .op5_i         (bus.op[5]),
        .alu_control_o (bus.ALUControl)
    );

    assign bus.ImmSrc    = IMMSRC_W'(imm_src);
    assign bus.ALUSrcA   = src_a;
    assign bus.ALUSrcB   = src_b;
    assign bus.ResultSrc = result_src;
    assign bus.AdrSrc    = adr_src;
    assign bus.IRWrite   = ir_write & ~reset;
    assign bus.PCWrite   = (pc_update | (branch & branch_cond)) & ~reset;
    assign bus.RegWrite  = reg_write & ~reset;
    assign bus.MemWrite  = mem_write & ~reset;
    assign bus.Illegal   = (state_q == S_TRAP);
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction phase model from the state/output
// table, randomized flags/MemReady/instructions, plus directed literal checks.
module tb_mc_controller;
    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB,
                      P_BR, P_J, P_JR, P_JRPC, P_LUI, P_T} phase_t;

    typedef struct packed {
        logic       rst;
        logic       cimm;
        logic       ca;
        logic       cb;
        logic [2:0] imm;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic       adr;
        logic [3:0] aluc;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } exp_t;

`ifdef MC_MEMREADY_EN
    localparam bit WAITS = 1'b1;
`else
    localparam bit WAITS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   snap_irw[32], snap_pcw[32], snap_rw[32], snap_mw[32], snap_aluc[32], snap_rs[32], snap_ill[32];

    mc_controller_if #(.ALUCTRL_W(4), .IMMSRC_W(3)) bus();

    mc_controller #(.ALUCTRL_W(4), .IMMSRC_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    function automatic bit known_op(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b1101111:             return 3'd3;
            7'b0110111, 7'b0010111: return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
        case (f3)
            3'd0:    return (f7b5 && op[5]) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return f7b5 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, n, c, v);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return n != v;
            3'd5:    return n == v;
            3'd6:    return !c;
            3'd7:    return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t exp_of(input phase_t ph, input logic [6:0] op, input logic [2:0] f3,
                                    input logic f7b5, input logic z, n, c, v, input logic mr);
        exp_t e;
        logic ok;
        ok     = WAITS ? mr : 1'b1;
        e      = '0;
        e.ca   = 1'b1;
        e.cb   = 1'b1;
        e.imm  = imm_of(op);
        e.cimm = known_op(op);
        case (ph)
            P_F:    begin e.a = 0; e.b = 2; e.rs = 2; e.irw = ok; e.pcw = ok; end
            P_D:    begin e.a = 1; e.b = 1; end
            P_MA:   begin e.a = 2; e.b = 1; end
            P_MR:   begin e.ca = 0; e.cb = 0; e.adr = 1; end
            P_MWB:  begin e.ca = 0; e.cb = 0; e.rs = 1; e.rw = 1; end
            P_MW:   begin e.ca = 0; e.cb = 0; e.adr = 1; e.mw = 1; end
            P_ER:   begin e.a = 2; e.b = 0; e.aluc = alu_of(op, f3, f7b5); end
            P_EI:   begin e.a = 2; e.b = 1; e.aluc = alu_of(op, f3, f7b5); end
            P_AWB:  begin e.ca = 0; e.cb = 0; e.rw = 1; end
            P_BR:   begin e.a = 2; e.b = 0; e.aluc = 1; e.pcw = taken(f3, z, n, c, v); end
            P_J:    begin e.a = 1; e.b = 2; e.pcw = 1; end
            P_JR:   begin e.a = 2; e.b = 1; end
            P_JRPC: begin e.a = 1; e.b = 2; e.pcw = 1; end
            P_LUI:  begin e.a = 3; e.b = 1; end
            default: begin e.ca = 0; e.cb = 0; e.ill = 1; end
        endcase
        return e;
    endfunction

    // Single compare process: every cycle with a pending expectation is checked.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("IRWrite", bus.IRWrite, e.irw);
            chk("PCWrite", bus.PCWrite, e.pcw);
            chk("RegWrite", bus.RegWrite, e.rw);
            chk("MemWrite", bus.MemWrite, e.mw);
            if (!e.rst) begin
                chk("Illegal", bus.Illegal, e.ill);
                chk("ResultSrc", bus.ResultSrc, e.rs);
                chk("AdrSrc", bus.AdrSrc, e.adr);
                chk("ALUControl", bus.ALUControl, e.aluc);
                if (e.cimm) chk("ImmSrc", bus.ImmSrc, e.imm);
                if (e.ca) chk("ALUSrcA", bus.ALUSrcA, e.a);
                if (e.cb) chk("ALUSrcB", bus.ALUSrcB, e.b);
            end
        end
    end

    task automatic drive_flags(input int flags);
        if (flags < 0) begin
            {bus.zero, bus.neg, bus.carry, bus.ovf} = 4'($urandom_range(0, 15));
        end else begin
            {bus.zero, bus.neg, bus.carry, bus.ovf} = 4'(flags);
        end
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reset = 1'b1;
            drive_flags(-1);
            bus.MemReady = 1'($urandom_range(0, 1));
            e = '0;
            e.rst = 1'b1;
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    // Runs one instruction through its phases; hold_mem<0 randomizes MemReady,
    // otherwise MEMREAD/MEMWRITE see hold_mem low cycles and everything else is ready.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                             input int flags, input int hold_mem, input int max_cyc, output int ncyc);
        phase_t seq[$];
        seq = {P_F, P_D};
        case (op)
            7'b0000011: seq = {seq, P_MA, P_MR, P_MWB};
            7'b0100011: seq = {seq, P_MA, P_MW};
            7'b0110011: seq = {seq, P_ER, P_AWB};
            7'b0010011: seq = {seq, P_EI, P_AWB};
            7'b1100011: seq = {seq, P_BR};
            7'b1101111: seq = {seq, P_J, P_AWB};
            7'b1100111: seq = {seq, P_JR, P_JRPC, P_AWB};
            7'b0110111: seq = {seq, P_LUI, P_AWB};
            7'b0010111: seq = {seq, P_AWB};
            default:    seq = {seq, P_T};
        endcase
        ncyc = 0;
        foreach (seq[k]) begin
            int waits = 0;
            forever begin
                @(posedge clk); #1;
                reset = 1'b0;
                if (ncyc == 0) begin
                    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7b5;
                end
                drive_flags(flags);
                if (hold_mem < 0) bus.MemReady = ($urandom_range(0, 3) != 0);
                else if (seq[k] == P_MR || seq[k] == P_MW) bus.MemReady = (waits >= hold_mem);
                else bus.MemReady = 1'b1;
                exp_q.push_back(exp_of(seq[k], op, f3, f7b5, bus.zero, bus.neg, bus.carry, bus.ovf, bus.MemReady));
                @(negedge clk);
                if (ncyc < 32) begin
                    snap_irw[ncyc] = bus.IRWrite;   snap_pcw[ncyc] = bus.PCWrite;
                    snap_rw[ncyc]  = bus.RegWrite;  snap_mw[ncyc]  = bus.MemWrite;
                    snap_aluc[ncyc] = bus.ALUControl; snap_rs[ncyc] = bus.ResultSrc;
                    snap_ill[ncyc] = bus.Illegal;
                end
                ncyc++;
                if (ncyc >= max_cyc) return;
                if (WAITS && (seq[k] inside {P_F, P_MR, P_MW}) && !bus.MemReady) waits++;
                else break;
            end
        end
    endtask

    task automatic trap_cycles(input int n, output int ill_seen, output int en_seen);
        ill_seen = 1; en_seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive_flags(-1);
            bus.MemReady = 1'($urandom_range(0, 1));
            exp_q.push_back(exp_of(P_T, bus.op, bus.funct3, bus.funct7b5, 1'b0, 1'b0, 1'b0, 1'b0, bus.MemReady));
            @(negedge clk);
            ill_seen &= int'(bus.Illegal);
            en_seen  |= int'(bus.IRWrite | bus.PCWrite | bus.RegWrite | bus.MemWrite);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] legal[9];
        logic [6:0] op;
        int n, ill_seen, en_seen, mw_cnt;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        reset = 1'b1;
        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.neg = 1'b0; bus.carry = 1'b0; bus.ovf = 1'b0;
        bus.MemReady = 1'b1;
        do_reset(2);

        // add: FETCH, DECODE, EXECR, ALUWB
        run_instr(7'b0110011, 3'd0, 1'b0, -1, 0, 99, n);
        chk("lit_first_irw", snap_irw[0], 1);
        chk("lit_first_pcw", snap_pcw[0], 1);
        chk("lit_first_ill", snap_ill[0], 0);
        chk("lit_add_cycles", n, 4);
        chk("lit_add_aluc", snap_aluc[2], 0);
        chk("lit_add_rw", snap_rw[3], 1);
        run_instr(7'b0110011, 3'd0, 1'b1, -1, 0, 99, n);
        chk("lit_sub_aluc", snap_aluc[2], 1);
        // blt N=1 V=0 -> taken; bgeu C=0 -> not taken
        run_instr(7'b1100011, 3'd4, 1'b0, 4'b0100, 0, 99, n);
        chk("lit_blt_pcw", snap_pcw[2], 1);
        chk("lit_blt_cycles", n, 3);
        run_instr(7'b1100011, 3'd7, 1'b0, 4'b0000, 0, 99, n);
        chk("lit_bgeu_pcw", snap_pcw[2], 0);
        chk("lit_bgeu_cycles", n, 3);
        run_instr(7'b1100111, 3'd0, 1'b0, -1, 0, 99, n);
        chk("lit_jalr_cycles", n, 5);
        chk("lit_jalrpc_pcw", snap_pcw[3], 1);
        chk("lit_jalrpc_rs", snap_rs[3], 0);
        chk("lit_jalr_rw", snap_rw[4], 1);
        run_instr(7'b0010111, 3'd0, 1'b0, -1, 0, 99, n);
        chk("lit_auipc_cycles", n, 3);
        run_instr(7'b0000011, 3'd2, 1'b0, -1, 3, 99, n);
        chk("lit_load_cycles", n, WAITS ? 8 : 5);
        run_instr(7'b0100011, 3'd2, 1'b0, -1, 2, 99, n);
        mw_cnt = 0;
        for (int i = 0; i < n; i++) mw_cnt += snap_mw[i];
        chk("lit_store_mw_cycles", mw_cnt, WAITS ? 3 : 1);

        // Illegal opcode traps until reset
        run_instr(7'b0000000, 3'd0, 1'b0, -1, 0, 99, n);
        chk("lit_trap_ill", snap_ill[2], 1);
        trap_cycles(10, ill_seen, en_seen);
        chk("lit_trap_ill_held", ill_seen, 1);
        chk("lit_trap_no_enables", en_seen, 0);
        do_reset(1);
        run_instr(7'b0110111, 3'd0, 1'b0, -1, 0, 99, n);
        chk("lit_ill_cleared", snap_ill[0], 0);
        chk("lit_lui_cycles", n, 4);

        // Reset during ALUWB of an add abandons it with no RegWrite
        run_instr(7'b0110011, 3'd0, 1'b0, -1, 0, 3, n);
        do_reset(1);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 29) == 0) begin
                do op = 7'($urandom_range(0, 127)); while (known_op(op));
                run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1, 99, n);
                trap_cycles(3, ill_seen, en_seen);
                do_reset(1);
            end else begin
                op = legal[$urandom_range(0, 8)];
                run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1, 99, n);
            end
        end

        @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
